insmem_loader: RTL and testbench
================================

INSMEM_LOADER -- requirements
Module: insmem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 2048, meaning instruction memory depth in bytes.
REQ-002 SHALL have ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  instruction fields presented
- in_ready  output  1  loader can accept fields
- icode  input  4  instruction code
- ifun  input  4  function code
- rA  input  4  register A specifier
- rB  input  4  register B specifier
- valC  input  64  constant / destination
- ptr_load  input  1  load write pointer
- ptr_val  input  12  new write pointer value
- mem_we  output  1  byte write strobe to instruction memory
- mem_addr  output  11  byte address
- mem_wdata  output  8  byte data
- wr_ptr  output  12  next free byte address
- ins_er  output  1  one-cycle pulse: invalid icode rejected
- adr_er  output  1  one-cycle pulse: instruction would overflow memory
- inst_count  output  16  instructions fully written

Function
REQ-003 SHALL implement FSM states IDLE and WRITE.
REQ-004 in_ready SHALL be 1 only in IDLE with ptr_load=0.
REQ-005 On in_valid&in_ready, loader SHALL capture all fields and compute length:
- icode 0,1,9 -> 1
- icode 2,6,A,B -> 2
- icode 7,8 -> 9
- icode 3,4,5 -> 10
REQ-006 Byte image SHALL be:
- byte0 = {icode,ifun} (icode in bits 7:4)
- byte1 = {rA,rB} for lengths 2 and 10
- valC little-endian in bytes 2..9 (icode 3-5) or bytes 1..8 (icode 7,8)
REQ-007 Accepted icode > 0xB SHALL pulse ins_er the next cycle, write nothing, leave wr_ptr unchanged, and stay in IDLE.
REQ-008 Accepted valid icode with wr_ptr+length > MEM_SIZE SHALL pulse adr_er the next cycle, write nothing, and stay in IDLE.
REQ-009 Otherwise FSM SHALL enter WRITE the cycle after acceptance and emit exactly one byte per cycle with mem_we=1, mem_addr=wr_ptr+k, k=0..length-1.
REQ-010 After the last byte, the FSM SHALL return to IDLE, advance wr_ptr by length, and increment inst_count (wrapping at 0xFFFF).
REQ-011 Accept-to-first-byte latency SHALL be 1 cycle; in_ready SHALL reassert in the cycle after the last byte.
REQ-012 mem_we SHALL be 0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-013 ptr_load in IDLE SHALL set wr_ptr=ptr_val next cycle and take priority over in_valid; ptr_load in WRITE SHALL be ignored.
REQ-014 ptr_val > MEM_SIZE SHALL be loaded as-is; the next instruction then raises adr_er.
REQ-015 An instruction exactly filling memory (wr_ptr+length = MEM_SIZE) SHALL be written, leaving wr_ptr = MEM_SIZE.

Reset
REQ-016 rst SHALL take priority over all inputs and force state=IDLE, wr_ptr=0, inst_count=0, mem_we=0, ins_er=0, adr_er=0, mem_addr=0, mem_wdata=0.
REQ-017 rst asserted mid-WRITE SHALL abort the instruction; bytes already written remain, and wr_ptr and inst_count SHALL not reflect it.

Configuration
REQ-018 With HLT_LOCK_EN defined, after a halt (icode 0) is fully written the loader SHALL hold in_ready=0 and ignore ptr_load until rst; without the macro, halt SHALL be treated as any 1-byte instruction.

Verification
REQ-019 Reset, then irmovq icode=3, ifun=0, rA=F, rB=2, valC=0x0123456789ABCDEF -> 10 writes at addr 0..9: 30,F2,EF,CD,AB,89,67,45,23,01; wr_ptr=10; inst_count=1.
REQ-020 Back-to-back: call icode=8, valC=0x100, then ret icode=9 -> 9 bytes 80,00,01,00x6, then in_ready for 1 cycle, then byte 90; wr_ptr=10.
REQ-021 icode=0xC -> ins_er pulse 1 cycle, no mem_we, wr_ptr unchanged.
REQ-022 ptr_load ptr_val=2040, then irmovq -> adr_er pulse, no writes; ptr_val=2038 with the same irmovq -> writes 2038..2047, wr_ptr=2048.
REQ-023 rst asserted on the 4th byte of irmovq -> mem_we=0 next cycle, wr_ptr=0, inst_count=0.
REQ-024 With HLT_LOCK_EN defined, halt then nop -> byte 00 written, in_ready stays 0, nop never written; without the macro, nop writes 10 at addr 1.

Source files
------------

// File: rtl/insmem_loader.sv
// insmem_loader: streams Y86-style instruction fields into a byte-wide
// instruction memory, one byte per cycle, tracking the next free address.
// Optional feature macro: HLT_LOCK_EN -- when defined, a fully written halt
// (icode 0) locks the loader (in_ready=0, ptr_load ignored) until rst.
module insmem_loader #(
  parameter int MEM_SIZE = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic        ptr_load,
  input  logic [11:0] ptr_val,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [11:0] wr_ptr,
  output logic        ins_er,
  output logic        adr_er,
  output logic [15:0] inst_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [12:0] MEM_LIMIT = 13'(MEM_SIZE);

  state_t      state_q;
  logic [11:0] wr_ptr_q;
  logic [15:0] inst_count_q;
  logic [3:0]  ra_q, rb_q;
  logic [63:0] valc_q;
  logic [3:0]  len_q;
  logic [3:0]  k_q;
  logic        mem_we_q;
  logic [10:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        ins_er_q;
  logic        adr_er_q;
  logic        locked;
  logic [3:0]  in_len;
  logic [12:0] end_addr;
  logic [7:0]  next_byte;

`ifdef HLT_LOCK_EN
  logic lock_q;
  logic halt_q;
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  // Encoded length in bytes for each icode; 0 marks an invalid code.
  function automatic logic [3:0] ins_len(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h9:             ins_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       ins_len = 4'd2;
      4'h7, 4'h8:                   ins_len = 4'd9;
      4'h3, 4'h4, 4'h5:             ins_len = 4'd10;
      default:                      ins_len = 4'd0;
    endcase
  endfunction

  // Byte k (k >= 1) of the captured instruction image.
  function automatic logic [7:0] image_byte(input logic [3:0] len, input logic [3:0] ra,
                                            input logic [3:0] rb, input logic [63:0] vc,
                                            input logic [3:0] k);
    logic [63:0] sh;
    logic [3:0]  idx;
    idx = (len == 4'd10) ? (k - 4'd2) : (k - 4'd1);
    sh  = vc >> {idx, 3'b000};
    if ((len == 4'd2 || len == 4'd10) && k == 4'd1)
      image_byte = {ra, rb};
    else
      image_byte = sh[7:0];
  endfunction

  // Acceptance qualifiers and the byte emitted on the next WRITE cycle.
  always_comb begin
    in_len    = ins_len(icode);
    end_addr  = {1'b0, wr_ptr_q} + {9'd0, in_len};
    next_byte = image_byte(len_q, ra_q, rb_q, valc_q, k_q);
  end

  assign in_ready   = (state_q == IDLE) && !ptr_load && !locked;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_ptr     = wr_ptr_q;
  assign ins_er     = ins_er_q;
  assign adr_er     = adr_er_q;
  assign inst_count = inst_count_q;

  // Loader FSM: accept/validate in IDLE, stream one byte per cycle in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      inst_count_q <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      valc_q       <= '0;
      len_q        <= '0;
      k_q          <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ins_er_q     <= 1'b0;
      adr_er_q     <= 1'b0;
`ifdef HLT_LOCK_EN
      lock_q       <= 1'b0;
      halt_q       <= 1'b0;
`endif
    end else begin
      ins_er_q <= 1'b0;
      adr_er_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (ptr_load && !locked) begin
            wr_ptr_q <= ptr_val;
          end else if (in_valid && in_ready) begin
            if (icode > 4'hB) begin
              ins_er_q <= 1'b1;
            end else if (end_addr > MEM_LIMIT) begin
              adr_er_q <= 1'b1;
            end else begin
              // Byte 0 goes out on the cycle right after acceptance.
              ra_q        <= rA;
              rb_q        <= rB;
              valc_q      <= valC;
              len_q       <= in_len;
              k_q         <= 4'd1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= wr_ptr_q[10:0];
              mem_wdata_q <= {icode, ifun};
              state_q     <= WRITE;
`ifdef HLT_LOCK_EN
              halt_q      <= (icode == 4'h0);
`endif
            end
          end
        end
        WRITE: begin
          if (k_q < len_q) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_ptr_q[10:0] + {7'd0, k_q};
            mem_wdata_q <= next_byte;
            k_q         <= k_q + 4'd1;
          end else begin
            // Last byte was emitted in the previous cycle: commit it.
            mem_we_q     <= 1'b0;
            state_q      <= IDLE;
            wr_ptr_q     <= wr_ptr_q + {8'd0, len_q};
            inst_count_q <= inst_count_q + 16'd1;
`ifdef HLT_LOCK_EN
            if (halt_q) lock_q <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insmem_loader.sv
// Directed self-checking bench for insmem_loader.
module tb_insmem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        ptr_load;
  logic [11:0] ptr_val;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [11:0] wr_ptr;
  logic        ins_er, adr_er;
  logic [15:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wb_data [0:19];
  logic [10:0] wb_addr [0:19];
  int          wb_n;

  logic [7:0] exp_irm  [0:9] = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] exp_call [0:8] = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  insmem_loader #(.MEM_SIZE(2048)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .ptr_load(ptr_load), .ptr_val(ptr_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr), .ins_er(ins_er), .adr_er(adr_er), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present fields, wait (bounded) for in_ready, hold through one accepting edge.
  task automatic send(input logic [3:0] c, input logic [3:0] f, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] v);
    int waitc = 0;
    icode = c; ifun = f; rA = a; rB = b; valC = v;
    while (in_ready !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    checks++;
    if (waitc >= 20) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Record every write strobe from now until mem_we drops (bounded).
  task automatic capture();
    wb_n = 0;
    while (mem_we === 1'b1 && wb_n < 20) begin
      wb_data[wb_n] = mem_wdata;
      wb_addr[wb_n] = mem_addr;
      wb_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mem_we !== 1'b0 || ins_er !== 1'b0 || adr_er !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: we/ins/adr=%b%b%b, required 000", mem_we, ins_er, adr_er);
    end
    checks++;
    if (wr_ptr !== 12'd0 || inst_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: wr_ptr=%0d inst_count=%0d, required 0 0", wr_ptr, inst_count);
    end
    checks++;
    if (mem_addr !== 11'd0 || mem_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%0d wdata=%h, required 0 00", mem_addr, mem_wdata);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    $display("reset: wr_ptr=%0d inst_count=%0d in_ready=%b", wr_ptr, inst_count, in_ready);
  endtask

  task automatic test_irmovq();
    do_reset();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    capture();
    checks++;
    if (wb_n != 10) begin
      errors++;
      $display("FAIL irmovq_len: got %0d writes, required 10", wb_n);
    end
    for (int i = 0; i < 10 && i < wb_n; i++) begin
      checks++;
      if (wb_data[i] !== exp_irm[i] || wb_addr[i] !== 11'(i)) begin
        errors++;
        $display("FAIL irmovq_byte%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wb_addr[i], wb_data[i], i, exp_irm[i]);
      end
    end
    checks++;
    if (wr_ptr !== 12'd10 || inst_count !== 16'd1) begin
      errors++;
      $display("FAIL irmovq_commit: wr_ptr=%0d inst_count=%0d, required 10 1", wr_ptr, inst_count);
    end
    $display("irmovq: %0d writes, wr_ptr=%0d inst_count=%0d", wb_n, wr_ptr, inst_count);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h100);
    // ret waits with in_valid high while the call streams out
    icode = 4'h9; ifun = 4'h0; valC = 64'h0;
    in_valid = 1'b1;
    capture();
    checks++;
    if (wb_n != 9) begin
      errors++;
      $display("FAIL call_len: got %0d writes, required 9", wb_n);
    end
    for (int i = 0; i < 9 && i < wb_n; i++) begin
      checks++;
      if (wb_data[i] !== exp_call[i] || wb_addr[i] !== 11'(i)) begin
        errors++;
        $display("FAIL call_byte%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 i, wb_addr[i], wb_data[i], i, exp_call[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL gap_cycle: in_ready=%b mem_we=%b, required 1 0", in_ready, mem_we);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 8'h90 || mem_addr !== 11'd9 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ret_byte: we=%b addr=%0d data=%h rdy=%b, required 1 9 90 0",
               mem_we, mem_addr, mem_wdata, in_ready);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || wr_ptr !== 12'd10 || inst_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_commit: we=%b wr_ptr=%0d count=%0d, required 0 10 2", mem_we, wr_ptr, inst_count);
    end
    $display("back_to_back: wr_ptr=%0d inst_count=%0d", wr_ptr, inst_count);
  endtask

  task automatic test_ins_er();
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    checks++;
    if (ins_er !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ins_er_pulse: ins_er=%b mem_we=%b, required 1 0", ins_er, mem_we);
    end
    tick();
    checks++;
    if (ins_er !== 1'b0 || mem_we !== 1'b0 || wr_ptr !== 12'd10 || inst_count !== 16'd2) begin
      errors++;
      $display("FAIL ins_er_after: ins_er=%b we=%b wr_ptr=%0d count=%0d, required 0 0 10 2",
               ins_er, mem_we, wr_ptr, inst_count);
    end
    $display("ins_er: wr_ptr=%0d in_ready=%b", wr_ptr, in_ready);
  endtask

  task automatic test_adr_er();
    // ptr_load beats a simultaneous in_valid
    ptr_load = 1'b1; ptr_val = 12'd2040;
    icode = 4'h1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ptr_load_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    ptr_load = 1'b0; in_valid = 1'b0;
    checks++;
    if (wr_ptr !== 12'd2040 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ptr_load: wr_ptr=%0d mem_we=%b, required 2040 0", wr_ptr, mem_we);
    end
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    checks++;
    if (adr_er !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL adr_er_pulse: adr_er=%b mem_we=%b, required 1 0", adr_er, mem_we);
    end
    tick();
    checks++;
    if (adr_er !== 1'b0 || wr_ptr !== 12'd2040) begin
      errors++;
      $display("FAIL adr_er_after: adr_er=%b wr_ptr=%0d, required 0 2040", adr_er, wr_ptr);
    end
    ptr_load = 1'b1; ptr_val = 12'd2038;
    tick();
    ptr_load = 1'b0;
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    capture();
    checks++;
    if (wb_n != 10 || wb_addr[0] !== 11'd2038 || wb_addr[9] !== 11'd2047 || wb_data[9] !== 8'h01) begin
      errors++;
      $display("FAIL fill_writes: n=%0d first=%0d last=%0d lastdata=%h, required 10 2038 2047 01",
               wb_n, wb_addr[0], wb_addr[9], wb_data[9]);
    end
    checks++;
    if (wr_ptr !== 12'd2048 || inst_count !== 16'd3) begin
      errors++;
      $display("FAIL fill_commit: wr_ptr=%0d count=%0d, required 2048 3", wr_ptr, inst_count);
    end
    // pointer beyond the memory is accepted, then the next instruction errors
    ptr_load = 1'b1; ptr_val = 12'd3000;
    tick();
    ptr_load = 1'b0;
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    checks++;
    if (wr_ptr !== 12'd3000 || adr_er !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL big_ptr: wr_ptr=%0d adr_er=%b we=%b, required 3000 1 0", wr_ptr, adr_er, mem_we);
    end
    tick();
    $display("adr_er: wr_ptr=%0d inst_count=%0d", wr_ptr, inst_count);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    tick();
    tick();
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 11'd3 || mem_wdata !== 8'hCD) begin
      errors++;
      $display("FAIL mid_fourth_byte: we=%b addr=%0d data=%h, required 1 3 cd", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || wr_ptr !== 12'd0 || inst_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: we=%b wr_ptr=%0d count=%0d, required 0 0 0", mem_we, wr_ptr, inst_count);
    end
    $display("reset_mid_write: wr_ptr=%0d inst_count=%0d", wr_ptr, inst_count);
  endtask

  task automatic test_halt();
    do_reset();
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    capture();
    checks++;
    if (wb_n != 1 || wb_data[0] !== 8'h00 || wb_addr[0] !== 11'd0) begin
      errors++;
      $display("FAIL halt_write: n=%0d addr=%0d data=%h, required 1 0 00", wb_n, wb_addr[0], wb_data[0]);
    end
`ifdef HLT_LOCK_EN
    begin
      int we_seen = 0;
      icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
      ptr_load = 1'b1; ptr_val = 12'd100;
      tick();
      ptr_load = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (mem_we === 1'b1 || in_ready !== 1'b0) we_seen++;
        tick();
      end
      in_valid = 1'b0;
      checks++;
      if (we_seen != 0 || wr_ptr !== 12'd1) begin
        errors++;
        $display("FAIL halt_lock: bad_cycles=%0d wr_ptr=%0d, required 0 1", we_seen, wr_ptr);
      end
    end
`else
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    capture();
    checks++;
    if (wb_n != 1 || wb_data[0] !== 8'h10 || wb_addr[0] !== 11'd1 || wr_ptr !== 12'd2) begin
      errors++;
      $display("FAIL nop_after_halt: n=%0d addr=%0d data=%h wr_ptr=%0d, required 1 1 10 2",
               wb_n, wb_addr[0], wb_data[0], wr_ptr);
    end
`endif
    $display("halt: wr_ptr=%0d inst_count=%0d in_ready=%b", wr_ptr, inst_count, in_ready);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ptr_load = 1'b0; ptr_val = '0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_ins_er();
    test_adr_er();
    test_reset_mid_write();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
